// File: rtl/mod7_step_decoder_if.sv
// Sample/clear inputs and decoded status outputs of the mod-7 step decoder.
// The decoder takes the slave side; the driving logic takes the master side.
interface mod7_step_decoder_if #(
    parameter int POS_W = 16,
    parameter int ERR_W = 8
);
    logic             sample_en;
    logic [2:0]       q_in;
    logic             clr;
    logic             dir;
    logic             step;
    logic             wrap_up;
    logic             wrap_dn;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [POS_W-1:0] position;
    logic             locked;
    logic             fault;

    modport master (
        output sample_en, q_in, clr,
        input  dir, step, wrap_up, wrap_dn, err,
        input  err_cnt, position, locked, fault
    );

    modport slave (
        input  sample_en, q_in, clr,
        output dir, step, wrap_up, wrap_dn, err,
        output err_cnt, position, locked, fault
    );
endinterface

// File: rtl/mod7_step_decoder.sv
// Decodes a mod-7 up/down count stream into direction, position and health.
// Locks after a streak of clean steps and faults on a run of bad samples.
module mod7_step_decoder #(
    parameter int LOCK_CNT    = 3,
    parameter int FAULT_LIMIT = 4,
    parameter int POS_W       = 16,
    parameter int ERR_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod7_step_decoder_if.slave   bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int FW = $clog2(FAULT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        FAULT
    } state_t;

    state_t        state;
    logic [2:0]    prev;
    logic [GW-1:0] good_cnt;
    logic [FW-1:0] fault_run;

    logic [2:0] nxt_up;
    logic [2:0] nxt_dn;
    logic       is_ill;
    logic       is_hold;
    logic       is_up;
    logic       is_dn;
    logic       is_skip;
    logic       err_now;

    always_comb begin
        nxt_up  = (prev == 3'd6) ? 3'd0 : prev + 3'd1;
        nxt_dn  = (prev == 3'd0) ? 3'd6 : prev - 3'd1;
        is_ill  = (bus.q_in == 3'd7);
        is_hold = (bus.q_in == prev);
        is_up   = (bus.q_in == nxt_up);
        is_dn   = (bus.q_in == nxt_dn);
        is_skip = !is_ill && !is_hold && !is_up && !is_dn;
        // IDLE has no reference yet, so only illegal codes are errors there
        err_now = is_ill || (is_skip && state != IDLE);
    end

    assign bus.locked = (state == LOCKED);
    assign bus.fault  = (state == FAULT);

    always_ff @(posedge clk) begin
        bus.step    <= 1'b0;
        bus.wrap_up <= 1'b0;
        bus.wrap_dn <= 1'b0;
        bus.err     <= 1'b0;
        if (!rst_n || bus.clr) begin
            state        <= IDLE;
            prev         <= 3'd0;
            good_cnt     <= '0;
            fault_run    <= '0;
            bus.position <= '0;
            bus.err_cnt  <= '0;
            bus.dir      <= 1'b1;
        end else if (bus.sample_en) begin
            if (err_now) begin
                bus.err <= 1'b1;
                if (bus.err_cnt != '1)
                    bus.err_cnt <= bus.err_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (!is_ill) begin
                        prev     <= bus.q_in;
                        good_cnt <= '0;
                        state    <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    unique case (1'b1)
                        is_ill: state <= IDLE;
                        is_up, is_dn: begin
                            good_cnt <= good_cnt + 1'b1;
                            prev     <= bus.q_in;
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                fault_run <= '0;
                            end
                        end
                        is_skip: begin
                            good_cnt <= '0;
                            prev     <= bus.q_in;
                        end
                        default: ;
                    endcase
                end
                LOCKED: begin
                    unique case (1'b1)
                        is_up: begin
                            bus.position <= bus.position + 1'b1;
                            bus.dir      <= 1'b1;
                            bus.step     <= 1'b1;
                            bus.wrap_up  <= (prev == 3'd6);
                            prev         <= bus.q_in;
                            fault_run    <= '0;
                        end
                        is_dn: begin
                            bus.position <= bus.position - 1'b1;
                            bus.dir      <= 1'b0;
                            bus.step     <= 1'b1;
                            bus.wrap_dn  <= (prev == 3'd0);
                            prev         <= bus.q_in;
                            fault_run    <= '0;
                        end
                        is_skip, is_ill: begin
                            if (is_skip)
                                prev <= bus.q_in;
                            fault_run <= fault_run + 1'b1;
                            if (fault_run == FW'(FAULT_LIMIT - 1))
                                state <= FAULT;
                        end
                        default: ;
                    endcase
                end
                FAULT: begin
                    if (!is_ill)
                        prev <= bus.q_in;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod7_step_decoder.sv
// Self-checking bench: directed scenarios plus a randomized run
// compared against an arithmetic model of the decoder rules.
module tb_mod7_step_decoder;
    localparam int LOCK_CNT    = 3;
    localparam int FAULT_LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    mod7_step_decoder_if #(.POS_W(16), .ERR_W(8)) bus();
    mod7_step_decoder_if #(.POS_W(16), .ERR_W(2)) bus2();

    mod7_step_decoder #(
        .LOCK_CNT(LOCK_CNT), .FAULT_LIMIT(FAULT_LIMIT),
        .POS_W(16), .ERR_W(8)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    mod7_step_decoder #(
        .LOCK_CNT(LOCK_CNT), .FAULT_LIMIT(FAULT_LIMIT),
        .POS_W(16), .ERR_W(2)
    ) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

    int checks = 0;
    int failures = 0;

    // model: mode 0 idle, 1 acquiring, 2 locked, 3 faulted
    int m_mode, m_prev, m_good, m_frun, m_pos, m_ecnt;
    bit m_dir, m_step, m_wu, m_wd, m_err;

    task automatic model(input bit r, input bit en, input int q, input bit c);
        int d;
        m_step = 0; m_wu = 0; m_wd = 0; m_err = 0;
        if (!r || c) begin
            m_mode = 0; m_prev = 0; m_good = 0; m_frun = 0;
            m_pos = 0; m_ecnt = 0; m_dir = 1;
        end else if (en) begin
            d = (q + 7 - m_prev) % 7;
            if (q == 7) m_err = 1;
            else if (d >= 2 && d <= 5 && m_mode != 0) m_err = 1;
            if (m_err && m_ecnt < 255) m_ecnt++;
            case (m_mode)
                0: if (q != 7) begin
                    m_prev = q; m_good = 0; m_mode = 1;
                end
                1: begin
                    if (q == 7) m_mode = 0;
                    else if (d == 1 || d == 6) begin
                        m_good++; m_prev = q;
                        if (m_good == LOCK_CNT) begin
                            m_mode = 2; m_frun = 0;
                        end
                    end else if (d != 0) begin
                        m_good = 0; m_prev = q;
                    end
                end
                2: begin
                    if (q != 7 && (d == 1 || d == 6)) begin
                        m_pos = (d == 1) ? m_pos + 1 : m_pos - 1;
                        m_dir = (d == 1);
                        m_step = 1;
                        m_wu = (d == 1 && m_prev == 6);
                        m_wd = (d == 6 && m_prev == 0);
                        m_prev = q; m_frun = 0;
                    end else if (q == 7 || d != 0) begin
                        if (q != 7) m_prev = q;
                        m_frun++;
                        if (m_frun == FAULT_LIMIT) m_mode = 3;
                    end
                end
                default: if (q != 7) m_prev = q;
            endcase
        end
    endtask

    task automatic drive(input bit r, input bit en, input int q, input bit c);
        rst_n = r;
        bus.sample_en = en;
        bus.q_in = 3'(q);
        bus.clr = c;
        @(posedge clk); #1;
        model(r, en, q, c);
    endtask

    task automatic samp(input int q);
        drive(1, 1, q, 0);
    endtask

    task automatic test_reset;
        drive(0, 1, 3, 1);
        drive(0, 0, 0, 0);
        checks++;
        if ({bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err,
             bus.locked, bus.fault} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags got %b want 1000000",
                {bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err,
                 bus.locked, bus.fault});
        end
        checks++;
        if (bus.err_cnt !== 8'd0 || bus.position !== 16'd0) begin
            failures++;
            $display("FAIL reset_counts got ecnt=%0d pos=%0d want 0 0",
                bus.err_cnt, bus.position);
        end
    endtask

    task automatic test_count_up;
        int seq[9] = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
        int wu_n = 0;
        int wu_at = -1;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            samp(seq[i]);
            if (bus.wrap_up) begin wu_n++; wu_at = i; end
            if (i == 2) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    failures++;
                    $display("FAIL early_lock got %b want 0", bus.locked);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.locked !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_on_3 got %b want 1", bus.locked);
                end
            end
        end
        checks++;
        if (bus.position !== 16'd5) begin
            failures++;
            $display("FAIL up_position got %0d want 5", bus.position);
        end
        checks++;
        if (wu_n != 1 || wu_at != 7) begin
            failures++;
            $display("FAIL wrap_up got n=%0d at=%0d want n=1 at=7", wu_n, wu_at);
        end
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL up_err_cnt got %0d want 0", bus.err_cnt);
        end
    endtask

    task automatic test_count_down;
        int seq[6] = '{0, 6, 5, 4, 3, 2};
        int wd_n = 0;
        drive(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            samp(seq[i]);
            if (bus.wrap_dn) wd_n++;
        end
        checks++;
        if (bus.dir !== 1'b0 || bus.position !== 16'hFFFE || wd_n != 0) begin
            failures++;
            $display("FAIL down got dir=%b pos=%h wd=%0d want 0 fffe 0",
                bus.dir, bus.position, wd_n);
        end
    endtask

    task automatic test_skip_recover;
        drive(1, 0, 0, 1);
        samp(6); samp(0); samp(1); samp(2);
        samp(4);
        checks++;
        if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1 || bus.position !== 16'd0) begin
            failures++;
            $display("FAIL skip got err=%b ecnt=%0d pos=%0d want 1 1 0",
                bus.err, bus.err_cnt, bus.position);
        end
        samp(5);
        checks++;
        if (bus.step !== 1'b1 || bus.position !== 16'd1) begin
            failures++;
            $display("FAIL after_skip got step=%b pos=%0d want 1 1",
                bus.step, bus.position);
        end
        samp(7); samp(7); samp(7);
        checks++;
        if (bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL run_cleared got fault=%b want 0", bus.fault);
        end
    endtask

    task automatic test_fault_clr;
        int errs = 0;
        drive(1, 0, 0, 1);
        samp(0); samp(1); samp(2); samp(3);
        for (int i = 0; i < 4; i++) begin
            samp(7);
            if (bus.err) errs++;
            if (i == 2) begin
                checks++;
                if (bus.fault !== 1'b0) begin
                    failures++;
                    $display("FAIL early_fault got %b want 0", bus.fault);
                end
            end
        end
        checks++;
        if (bus.fault !== 1'b1 || errs != 4 || bus.err_cnt !== 8'd4) begin
            failures++;
            $display("FAIL fault got fault=%b errs=%0d ecnt=%0d want 1 4 4",
                bus.fault, errs, bus.err_cnt);
        end
        samp(4);
        checks++;
        if (bus.err !== 1'b0 || bus.position !== 16'd0 || bus.fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_prev got err=%b pos=%0d fault=%b want 0 0 1",
                bus.err, bus.position, bus.fault);
        end
        drive(1, 1, 2, 1);
        checks++;
        if ({bus.locked, bus.fault, bus.dir, bus.err} !== 4'b0010 ||
            bus.err_cnt !== 8'd0 || bus.position !== 16'd0) begin
            failures++;
            $display("FAIL clr got lfde=%b ecnt=%0d pos=%0d want 0010 0 0",
                {bus.locked, bus.fault, bus.dir, bus.err},
                bus.err_cnt, bus.position);
        end
    endtask

    task automatic test_hold;
        int ev = 0;
        drive(1, 0, 0, 1);
        samp(0); samp(1); samp(2); samp(3);
        for (int i = 0; i < 3; i++) begin
            samp(3);
            ev += int'(bus.step) + int'(bus.err);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, $urandom_range(0, 7), 0);
            ev += int'(bus.step) + int'(bus.err);
        end
        checks++;
        if (ev != 0 || bus.position !== 16'd0) begin
            failures++;
            $display("FAIL hold got events=%0d pos=%0d want 0 0", ev, bus.position);
        end
        samp(4);
        checks++;
        if (bus.step !== 1'b1 || bus.position !== 16'd1) begin
            failures++;
            $display("FAIL hold_resume got step=%b pos=%0d want 1 1",
                bus.step, bus.position);
        end
    endtask

    task automatic test_reset_override;
        int seq[11] = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 2, 3};
        drive(1, 0, 0, 1);
        for (int i = 0; i < 11; i++) samp(seq[i]);
        checks++;
        if (bus.position !== 16'd7) begin
            failures++;
            $display("FAIL pre_reset_pos got %0d want 7", bus.position);
        end
        drive(0, 1, 4, 1);
        checks++;
        if ({bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err,
             bus.locked, bus.fault} !== 7'b1000000 ||
            bus.err_cnt !== 8'd0 || bus.position !== 16'd0) begin
            failures++;
            $display("FAIL rst_override got flags=%b ecnt=%0d pos=%0d",
                {bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err,
                 bus.locked, bus.fault}, bus.err_cnt, bus.position);
        end
        samp(4);
        samp(5);
        samp(6);
        checks++;
        if (bus.locked !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reacq got locked=%b err=%b want 0 0",
                bus.locked, bus.err);
        end
        samp(0);
        checks++;
        if (bus.locked !== 1'b1 || bus.position !== 16'd0) begin
            failures++;
            $display("FAIL relock got locked=%b pos=%0d want 1 0",
                bus.locked, bus.position);
        end
    endtask

    task automatic test_err_sat;
        bus2.sample_en = 1'b0;
        bus2.q_in = 3'd7;
        bus2.clr = 1'b0;
        rst2_n = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1;
        bus2.sample_en = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus2.err_cnt !== 2'd3 || bus2.err !== 1'b1) begin
            failures++;
            $display("FAIL err_sat got ecnt=%0d err=%b want 3 1",
                bus2.err_cnt, bus2.err);
        end
        bus2.sample_en = 1'b0;
    endtask

    task automatic test_random;
        int k, q;
        bit r, c, en;
        logic [30:0] act, exp;
        drive(1, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) != 0);
            c  = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 5) != 0);
            k  = $urandom_range(0, 11);
            if (k <= 4) q = (m_prev + 1) % 7;
            else if (k <= 8) q = (m_prev + 6) % 7;
            else if (k == 9) q = m_prev;
            else if (k == 10) q = $urandom_range(0, 6);
            else q = 7;
            drive(r, en, q, c);
            act = {bus.dir, bus.step, bus.wrap_up, bus.wrap_dn, bus.err,
                   bus.locked, bus.fault, bus.err_cnt, bus.position};
            exp = {m_dir, m_step, m_wu, m_wd, m_err,
                   m_mode == 2, m_mode == 3, 8'(m_ecnt), 16'(m_pos)};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL random n=%0d q=%0d got %h want %h", n, q, act, exp);
            end
        end
    endtask

    initial begin
        bus.sample_en = 1'b0;
        bus.q_in = 3'd0;
        bus.clr = 1'b0;
        bus2.sample_en = 1'b0;
        bus2.q_in = 3'd0;
        bus2.clr = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_skip_recover();
        test_fault_clr();
        test_hold();
        test_reset_override();
        test_err_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mod7_step_decoder.md
# mod7_step_decoder

Receiver-side decoder for the 3-bit mod-7 up/down count stream (legal values 0..6). It samples the incoming count, infers direction per step, and flags skipped or illegal codes. It locks onto a clean sequence and keeps a signed position accumulator with wrap indications. It sits downstream of the mod-7 up/down counter and gives the control logic direction, position and health status.

## Interface
Parameters:
- LOCK_CNT, 3, consecutive good steps needed in ACQUIRE to enter LOCKED (>=1)
- FAULT_LIMIT, 4, consecutive errors in LOCKED that force FAULT (>=1)
- POS_W, 16, width of signed position accumulator
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- sample_en  in  1  q_in is sampled on this edge when 1; ignored when 0
- q_in  in  3  incoming mod-7 count
- clr  in  1  synchronous clear to IDLE (below rst_n, above sampling)
- dir  out  1  last decoded step direction in LOCKED: 1 = up, 0 = down
- step  out  1  one-cycle pulse: a counted step in LOCKED
- wrap_up  out  1  one-cycle pulse: LOCKED up step 6->0
- wrap_dn  out  1  one-cycle pulse: LOCKED down step 0->6
- err  out  1  one-cycle pulse: skip or illegal sample, in any state
- err_cnt  out  ERR_W  total errors, saturating at 2^ERR_W-1
- position  out  POS_W  signed step count, two's complement
- locked  out  1  state == LOCKED
- fault  out  1  state == FAULT

## Operation
- Sample classification (only when sample_en=1), against the registered prev:
  - illegal: q_in == 7
  - up: q_in == (prev+1) mod 7 (6->0 counts)
  - down: q_in == (prev-1) mod 7 (0->6 counts)
  - hold: q_in == prev. No step and no error.
  - skip: any other legal value
- err pulses and err_cnt increments (saturating) on every illegal or skip sample, in every state except IDLE-skip (no prev yet). An illegal sample in IDLE still counts.
- States:
  - IDLE:
    - legal sample: prev <= q_in, good_cnt <= 0, go to ACQUIRE
    - illegal sample: err, stay in IDLE
  - ACQUIRE:
    - up/down: good_cnt++, prev <= q_in; if good_cnt+1 == LOCK_CNT, go to LOCKED with fault_run <= 0
    - hold: no change; the streak is not broken
    - skip: good_cnt <= 0, prev <= q_in
    - illegal: go to IDLE
    - position is not updated in this state
  - LOCKED:
    - up: position+1, dir <= 1, step, prev <= q_in, fault_run <= 0; wrap_up if prev was 6
    - down: position-1, dir <= 0, step, prev <= q_in, fault_run <= 0; wrap_dn if prev was 0
    - hold: nothing changes, including fault_run
    - skip: prev <= q_in, position unchanged, fault_run++
    - illegal: prev unchanged, fault_run++
    - fault_run reaching FAULT_LIMIT: go to FAULT
  - FAULT: samples are still classified and counted in err_cnt. position and dir are frozen. The block leaves FAULT only through clr or rst_n.
- clr: state <= IDLE. position, err_cnt, good_cnt, fault_run and prev are zeroed. dir <= 1. Pulses are 0 on the next cycle.
- position wraps modulo 2^POS_W. There is no saturation.

## Timing
- All outputs are registered. A sample on edge k produces its pulses, its state change and its counter update visible after edge k. Pulses last exactly one cycle. Latency is 1 cycle.
- The step that achieves lock is not added to position. Counting starts with the next step.
- Reset (rst_n=0 at an edge) overrides clr and sample_en, including mid-LOCKED or mid-FAULT. After that edge:
  - state = IDLE
  - dir = 1
  - step = wrap_up = wrap_dn = err = 0
  - err_cnt = 0, position = 0, locked = 0, fault = 0, prev = 0
- clr=1 with sample_en=1: clr wins and the sample is discarded.
- sample_en=0: no state change. Pulses return to 0.

## Test plan
- Reset, then sample 0,1,2,3,4,5,6,0,1 on consecutive cycles (LOCK_CNT=3) -> locked rises after the sample of 3; position=5 at the end; wrap_up pulses once, on the sample of 0; err_cnt=0.
- After lock via 0,6,5,4, sample 3,2 -> dir=0; position=16'hFFFE; no wrap_dn pulse, because 0->6 occurred in ACQUIRE.
- Locked at 2, sample 4, then 5 -> err pulse on the 4; err_cnt=1; position unchanged; the 5 gives a step with position +1 and fault_run cleared.
- Locked, sample 7 four times (FAULT_LIMIT=4) -> four err pulses; fault=1 after the 4th; err_cnt=4; prev still the last legal value. Then clr -> IDLE with err_cnt=0 and position=0. With ERR_W=2, ten errors leave err_cnt=3.
- Locked at 3, sample 3,3,3 and toggle q_in with sample_en=0 -> no step, no err, position unchanged.
- Locked with position=7, assert rst_n=0 together with sample_en=1 and clr=1 -> all outputs at reset values after that edge; the next legal sample enters ACQUIRE.
